// File: rtl/alu_pkg.sv
// Shared opcode/state types and NZCV flag helpers for alu_seq.
// Used both with and without ALU_MUL_EN; the MUL opcode and BUSY state simply go unused when it is off.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_MUL   = 4'b1000,
        OP_LSL   = 4'b1001,
        OP_LSR   = 4'b1010,
        OP_NOR   = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier (low N bits), one multiplier bit per cycle, LSB first.
// Only instantiated by alu_seq when ALU_MUL_EN is defined.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int CW = $clog2(N);

    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  partial;

    always_comb begin
        partial  = mplier_q[0] ? mcand_q : '0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // The last bit's partial product is folded in combinationally so the
    // consumer can register the final value on the Nth busy edge.
    assign done    = busy_q && (cnt_q == CW'(N - 1));
    assign product = acc_q + partial;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered valid/ready ALU with NZCV flags; results held in DONE until handed off.
// Define ALU_MUL_EN to build in the iterative multiplier and BUSY state.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic [3:0]   flags
);

    localparam int SW = $clog2(N);

    alu_state_t    state_q, state_d;
    logic [N-1:0]  result_q, result_d;
    logic          zero_q, zero_d;
    logic [3:0]    flags_q, flags_d;

    logic          accept;
    logic [N:0]    sum;
    logic [N:0]    diff;
    logic [SW-1:0] shamt;
    logic [N-1:0]  alu_res;
    logic          alu_c;
    logic          alu_v;

    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};
    assign shamt    = b[SW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_ADD: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                // Carry is NOT borrow: set when a >= b unsigned.
                alu_res = diff[N-1:0];
                alu_c   = ~diff[N];
                alu_v   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_PASSB: alu_res = b;
            OP_NOR:   alu_res = ~(a | b);
            OP_LSL:   alu_res = a << shamt;
            OP_LSR:   alu_res = a >> shamt;
            default:  alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic         mul_start;
    logic         mul_done;
    logic [N-1:0] mul_product;

    assign mul_start = accept && (ALUControl == OP_MUL);

    alu_mul_iter #(
        .N(N)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (ALUControl == OP_MUL) begin
                        state_d = BUSY;
                    end else
`endif
                    begin
                        state_d  = DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        flags_d  = pack_flags(alu_res[N-1], alu_res == '0, alu_c, alu_v);
                    end
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (mul_done) begin
                    state_d  = DONE;
                    result_d = mul_product;
                    zero_d   = (mul_product == '0);
                    flags_d  = pack_flags(mul_product[N-1], mul_product == '0, 1'b0, 1'b0);
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (N=64) with a scoreboard of expected results.
// Expectations follow ALU_MUL_EN the same way the design does.
module tb_alu_seq;

    localparam int N = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [3:0]    alu_ctl;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  result;
    logic          zero;
    logic [3:0]    flags;

    typedef struct {
        logic [63:0] res;
        logic        z;
        logic [3:0]  f;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_seq #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .ALUControl (alu_ctl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .flags      (flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic [3:0] op);
        exp_t        e;
        logic [64:0] w;
        logic [63:0] r;
        logic        c;
        logic        v;
        c     = 1'b0;
        v     = 1'b0;
        e.lat = 1;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin
                w = {1'b0, x} + {1'b0, y};
                r = w[63:0];
                c = w[64];
                v = (x[63] == y[63]) && (r[63] != x[63]);
            end
            4'b0110: begin
                r = x - y;
                c = (x >= y);
                v = (x[63] != y[63]) && (r[63] != x[63]);
            end
            4'b0111: r = y;
            4'b1100: r = ~(x | y);
            4'b1001: r = x << y[5:0];
            4'b1010: r = x >> y[5:0];
`ifdef ALU_MUL_EN
            4'b1000: begin
                r     = x * y;
                e.lat = N + 1;
            end
`endif
            default: r = 64'd0;
        endcase
        e.res = r;
        e.z   = (r == 64'd0);
        e.f   = {r[63], (r == 64'd0), c, v};
        return e;
    endfunction

    // Presents one op for exactly one acceptance edge, then scrambles the inputs.
    task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic [3:0] op, input bit push);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        a        = x;
        b        = y;
        alu_ctl  = op;
        in_valid = 1'b1;
        if (push) sb.push_back(model(x, y, op));
        @(negedge clk);
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        alu_ctl  = 4'($urandom);
    endtask

    // Waits (bounded) for out_valid, compares against the scoreboard, holds, then hands off.
    task automatic collect(input int hold);
        exp_t        e;
        int          lat;
        logic [63:0] r0;
        logic [3:0]  f0;
        logic        z0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            check("in_ready_busy", in_ready, 1'b0);
            @(negedge clk);
            lat++;
        end
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard: observed empty expected entry");
            return;
        end
        e = sb.pop_front();
        check("latency", 64'(lat), 64'(e.lat));
        check("result", result, e.res);
        check("zero", zero, e.z);
        check("flags", flags, e.f);
        check("in_ready_done", in_ready, 1'b0);
        r0 = result;
        z0 = zero;
        f0 = flags;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_result", result, r0);
            check("hold_zero", zero, z0);
            check("hold_flags", flags, f0);
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", out_valid, 1'b0);
        $display("op done: result=%h zero=%0d flags=%b latency=%0d", r0, z0, f0, lat);
    endtask

    initial begin
        logic [3:0] ops [8];
        logic [63:0] x;
        logic [63:0] y;
        logic [3:0]  op;
        ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1010, 4'b1001, 4'b0111, 4'b1100};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        alu_ctl   = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 64'd0);
        check("rst_zero", zero, 1'b0);
        check("rst_flags", flags, 4'b0000);
        reset = 1'b0;
        #1;
        check("rst_release_in_ready", in_ready, 1'b1);

        issue(64'd3, 64'd3, 4'b0010, 1'b1);
        collect(0);
        issue(64'd3, 64'd3, 4'b0110, 1'b1);
        collect(0);
        issue(64'd0, 64'd0, 4'b1100, 1'b1);
        collect(0);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b1);
        collect(0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b1);
        collect(0);
        issue(64'd7, 64'd6, 4'b1000, 1'b1);
        collect(0);
        issue(64'hF0, 64'd64, 4'b1010, 1'b1);
        collect(0);
        issue(64'h1234, 64'h5678, 4'b0011, 1'b1);
        collect(0);
        issue(64'd2, 64'd5, 4'b0110, 1'b1);
        collect(0);

        // Backpressure with a second op waiting: it must not enter until the handoff.
        issue(64'd1, 64'd63, 4'b1001, 1'b1);
        a        = 64'h00FF_0000_0000_0001;
        b        = 64'h0F00_0000_0000_0010;
        alu_ctl  = 4'b0001;
        in_valid = 1'b1;
        collect(5);
        check("in_ready_after_hs", in_ready, 1'b1);
        sb.push_back(model(64'h00FF_0000_0000_0001, 64'h0F00_0000_0000_0010, 4'b0001));
        @(negedge clk);
        in_valid = 1'b0;
        collect(0);

        for (int i = 0; i < 8; i++) begin
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom};
            op = ops[$urandom_range(7)];
            issue(x, y, op, 1'b1);
            collect(0);
        end

        issue(64'd3, 64'd5, 4'b0001, 1'b1);
        collect(0);

        // Abandon an in-flight op with reset; its result must never appear.
`ifdef ALU_MUL_EN
        issue(64'd5, 64'd9, 4'b1000, 1'b0);
        repeat (9) @(negedge clk);
`else
        issue(64'd5, 64'd9, 4'b0010, 1'b0);
`endif
        reset = 1'b1;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_result", result, 64'd0);
        check("abort_zero", zero, 1'b0);
        check("abort_flags", flags, 4'b0000);
        reset = 1'b0;
        #1;
        check("abort_release_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 1'b0);
        end

        issue(64'd10, 64'd20, 4'b0010, 1'b1);
        collect(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked successor to the combinational datapath ALU: a width-parametrised ALU with NZCV flags, shift operations and an optional iterative multiplier. It sits between the register-read and write-back stages of the multi-cycle datapath. Operands are accepted with a valid/ready handshake, and results are held until the consumer takes them.

## Interface
- N, 64, operand/result width in bits; legal N ≥ 8, power of two.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept; equals (state==IDLE) && !reset.
- a  in  N  operand A.
- b  in  N  operand B.
- ALUControl  in  4  opcode, sampled only on acceptance.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- result  out  N  registered result.
- zero  out  1  registered; equals (result==0).
- flags  out  4  registered NZCV, [3]=N, [2]=Z, [1]=C, [0]=V.

## Operation
- Acceptance occurs when in_valid && in_ready. At acceptance, a, b and ALUControl are captured; later input changes are ignored.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a−b), 0111 PASS b, 1100 NOR.
  - 1000 MUL: low N bits of a*b, unsigned.
  - 1001 LSL: a << b[log2(N)−1:0].
  - 1010 LSR: logical a >> b[log2(N)−1:0].
  - Any other opcode gives result 0.
- Flags:
  - N = result[N−1].
  - Z = zero.
  - ADD: C = carry out of bit N−1; V = signed overflow.
  - SUB: C = NOT borrow (1 iff a ≥ b unsigned); V = signed overflow.
  - All other ops: C = V = 0.
- FSM states IDLE, BUSY, DONE:
  - IDLE → DONE on acceptance of a single-cycle op; result computed and registered in the acceptance cycle.
  - IDLE → BUSY on acceptance of MUL.
  - BUSY → DONE after N iteration cycles, one multiplier bit per cycle, LSB first, shift-add.
  - DONE → IDLE on out_valid && out_ready.
- out_valid = (state==DONE). result, zero and flags stay stable throughout DONE.
- No new operation is accepted before the current result is handed off. There is no bypass from DONE back to acceptance.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, zero 0, flags 0000, multiplier accumulator/counter 0. in_ready is 0 while reset is high.
- Single-cycle op latency: out_valid rises on the edge after acceptance. Peak throughput is one op per 2 cycles.
- MUL latency: out_valid rises N+1 edges after acceptance; 65 for N=64. in_ready is 0 for the whole of BUSY and DONE.
- Backpressure: with out_ready low, the block holds DONE indefinitely and outputs do not change.
- out_ready is ignored outside DONE.
- Reset asserted in BUSY or DONE:
  - The operation is abandoned and out_valid never asserts for it.
  - IDLE is reached on the reset edge.
  - in_ready returns to 1 in the first cycle reset is low.
- Arithmetic is modulo 2^N.
- Shift amounts use only the low log2(N) bits of b, so shift by N behaves as shift by 0.

## Configuration
- ALU_MUL_EN defined: the iterative multiplier and BUSY state are compiled in, and MUL behaves as above.
- ALU_MUL_EN undefined: no multiplier hardware and no BUSY state. Opcode 1000 is treated as an unsupported opcode: single-cycle, result 0, flags 0100, zero 1.

## Structure
- Package alu_pkg holds:
  - alu_op_t: 4-bit enum of the opcodes above.
  - alu_state_t: IDLE/BUSY/DONE.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_mul_iter, instantiated only under ALU_MUL_EN:
  - Parameter N.
  - Ports: clk, reset, start, a, b, done, product[N−1:0].
  - Performs shift-add, one cycle per bit; done is a 1-cycle pulse.

## Test plan
- ADD a=3, b=3 → result 6, zero 0, flags 0000; out_valid on the edge after acceptance.
- SUB a=3, b=3 → result 0, zero 1, flags 0110. Then NOR a=0, b=0 → result 0xFFFF_FFFF_FFFF_FFFF, flags 1000.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 → result 0x8000_0000_0000_0000, flags 1001. Then ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 → result 0, flags 0110.
- MUL a=7, b=6 (ALU_MUL_EN) → result 42 exactly 65 edges after acceptance; in_ready 0 throughout. Without the macro → result 0, flags 0100 after 1 edge.
- LSL a=1, b=63 → result 0x8000_0000_0000_0000. Hold out_ready=0 for 5 cycles → outputs stable, in_ready 0, second op accepted only after the handshake.
- Assert reset 10 cycles into a MUL → out_valid stays 0, all outputs at reset values, in_ready 1 in the first cycle after reset falls.
